// File: rtl/mult_ctrl.sv
// mult_ctrl: unsigned 16x16 shift-and-add multiply sequencer.
// It borrows the shared execute-stage ALU for both the accumulate add and the
// multiplicand shift, and returns the low 16 bits of the product with a sticky
// flag that is set when the full product does not fit in 16 bits.
module mult_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        ovf,
    output logic [15:0] aluA,
    output logic [15:0] aluB,
    output logic [2:0]  aluOp,
    output logic        aluCin,
    output logic        aluInvA,
    output logic        aluInvB,
    output logic        aluSign,
    input  logic [15:0] aluOut,
    input  logic        aluOfl
);

    localparam logic [2:0] OpAdd = 3'h4;
    localparam logic [2:0] OpSll = 3'h1;

    typedef enum logic [2:0] {
        StIdle,
        StStep,
        StAdd,
        StShift,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic        ovf_q, ovf_d;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= 16'h0000;
            mcand_q  <= 16'h0000;
            mplier_q <= 16'h0000;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state, datapath updates and the ALU request for the current state.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        ovf_d    = ovf_q;
        aluA     = 16'h0000;
        aluB     = 16'h0000;
        aluOp    = OpAdd;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d    = 16'h0000;
                    mcand_d  = opA;
                    mplier_d = opB;
                    ovf_d    = 1'b0;
                    state_d  = StStep;
                end
            end
            StStep: begin
                // Early exit once no multiplier bits remain.
                if (mplier_q == 16'h0000) begin
                    state_d = StDone;
                end else if (mplier_q[0]) begin
                    state_d = StAdd;
                end else begin
                    state_d = StShift;
                end
            end
            StAdd: begin
                aluA    = acc_q;
                aluB    = mcand_q;
                aluOp   = OpAdd;
                acc_d   = aluOut;
                ovf_d   = ovf_q | aluOfl;
                state_d = StShift;
            end
            StShift: begin
                aluA     = mcand_q;
                aluB     = 16'h0001;
                aluOp    = OpSll;
                mcand_d  = aluOut;
                mplier_d = mplier_q >> 1;
                // A multiplicand bit shifted out still has a multiplier bit to
                // meet, so the full product cannot fit in 16 bits.
                if (mcand_q[15] && (mplier_q[15:1] != 15'd0)) begin
                    ovf_d = 1'b1;
                end
                state_d = StStep;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Fixed ALU controls: unsigned, no carry-in, no operand inversion.
    always_comb begin
        aluCin  = 1'b0;
        aluInvA = 1'b0;
        aluInvB = 1'b0;
        aluSign = 1'b0;
    end

    assign busy   = (state_q != StIdle);
    assign result = acc_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: drives directed and random multiplies through mult_ctrl with a
// behavioural ALU attached, and checks product, overflow, latency and protocol
// against plain-arithmetic expectations.
module tb_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] opA, opB;
    logic        busy, done, ovf;
    logic [15:0] result;
    logic [15:0] aluA, aluB, aluOut;
    logic [2:0]  aluOp;
    logic        aluCin, aluInvA, aluInvB, aluSign, aluOfl;

    int checks = 0;
    int errors = 0;

    int n_add, n_shl;
    logic ctl_seen;

    mult_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .opA     (opA),
        .opB     (opB),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf),
        .aluA    (aluA),
        .aluB    (aluB),
        .aluOp   (aluOp),
        .aluCin  (aluCin),
        .aluInvA (aluInvA),
        .aluInvB (aluInvB),
        .aluSign (aluSign),
        .aluOut  (aluOut),
        .aluOfl  (aluOfl)
    );

    always #5 clk = ~clk;

    // Behavioural shared ALU: add with unsigned carry-out, or shift left.
    logic [16:0] alu_sum;
    assign alu_sum = {1'b0, aluA} + {1'b0, aluB};
    assign aluOut  = (aluOp == 3'h4) ? alu_sum[15:0] :
                     (aluOp == 3'h1) ? (aluA << aluB[3:0]) : 16'h0000;
    assign aluOfl  = (aluOp == 3'h4) ? alu_sum[16] : 1'b0;

    // Observe ALU usage between edges.
    always @(negedge clk) begin
        if (aluOp == 3'h1) n_shl++;
        if (aluOp == 3'h4 && (aluA != 16'h0 || aluB != 16'h0)) n_add++;
        if (aluCin || aluInvA || aluInvB || aluSign) ctl_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [15:0] b);
        int l = 2;
        int h = -1;
        for (int i = 0; i < 16; i++) if (b[i]) h = i;
        for (int i = 0; i <= h; i++) l += 2 + int'(b[i]);
        return l;
    endfunction

    // Present a start at the next negedge; it is sampled on the following posedge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        opA   = a;
        opB   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_add = 0;
        n_shl = 0;
    endtask

    // Run one multiply and check result, overflow, latency and done/busy shape.
    task automatic run_mult(input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [31:0] prod;
        int cyc;
        bit got_done;
        prod     = 32'(a) * 32'(b);
        cyc      = 0;
        got_done = 0;
        issue(a, b);
        while (!got_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({tag, " busy_rise"}, 32'(busy), 32'd1);
            if (done) got_done = 1;
        end
        chk({tag, " done_seen"}, 32'(got_done), 32'd1);
        chk({tag, " latency"}, cyc, exp_latency(b));
        chk({tag, " result"}, 32'(result), prod & 32'hFFFF);
        chk({tag, " ovf"}, 32'(ovf), 32'(prod >= 32'h10000));
        @(negedge clk);
        chk({tag, " done_fall"}, {31'd0, done, busy}, 32'd0);
        chk({tag, " result_hold"}, 32'(result), prod & 32'hFFFF);
    endtask

    initial begin
        int cyc;
        bit seen;
        logic [15:0] ra, rb;
        rst      = 1'b1;
        start    = 1'b0;
        opA      = 16'h0;
        opB      = 16'h0;
        ctl_seen = 1'b0;
        n_add    = 0;
        n_shl    = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset state", {26'd0, busy, done, ovf, 3'd0}, 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset alu", {13'd0, aluOp, aluA}, {13'd0, 3'h4, 16'h0});
        rst = 1'b0;

        run_mult(16'd3, 16'd5, "3x5");
        chk("3x5 adds", n_add, 2);
        chk("3x5 shifts", n_shl, 3);
        run_mult(16'h1234, 16'h0000, "b_zero");
        chk("b_zero alu", n_add + n_shl, 0);
        run_mult(16'hFFFF, 16'hFFFF, "max");
        run_mult(16'h8000, 16'd2, "msb_lost");
        run_mult(16'h8000, 16'd1, "msb_kept");
        run_mult(16'hFFFF, 16'd3, "add_carry");
        run_mult(16'h0000, 16'hFFFF, "a_zero");

        // start pulsed during a SHIFT of a running 3*5 must be ignored.
        issue(16'd3, 16'd5);
        cyc  = 0;
        seen = 0;
        while (aluOp != 3'h1 && cyc < 20) begin @(negedge clk); cyc++; end
        opA = 16'd9; opB = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!seen && cyc < 60) begin @(negedge clk); cyc++; if (done) seen = 1; end
        chk("busy_start done", 32'(seen), 32'd1);
        chk("busy_start result", 32'(result), 32'h000F);

        // Reset during ADD aborts without a done pulse.
        issue(16'd3, 16'd5);
        cyc = 0;
        while (!(aluOp == 3'h4 && aluB != 16'h0) && cyc < 20) begin @(negedge clk); cyc++; end
        rst = 1'b1;
        @(negedge clk);
        chk("abort state", {29'd0, busy, ovf, done}, 32'd0);
        chk("abort result", 32'(result), 32'd0);
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin @(negedge clk); if (done || busy) seen = 1; end
        chk("abort quiet", 32'(seen), 32'd0);
        run_mult(16'd7, 16'd7, "7x7");

        // Random operands, with the multiplier often narrowed to vary latency.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 3 == 0) rb = rb & 16'h00FF;
            if (i % 5 == 1) ra = ra & 16'h00FF;
            run_mult(ra, rb, "rand");
        end

        chk("alu ctl tied low", 32'(ctl_seen), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Multi-cycle unsigned 16x16 multiply sequencer that borrows the shared 16-bit ALU and runs shift-and-add over it. It sits beside the execute-stage ALU and drives the ALU's operand and control inputs (A, B, Op, Cin, invA, invB, sign) through a mux owned by the execute stage. It reads back Out/Ofl and returns the low 16 bits of the product with an unsigned-overflow flag.

## Interface
- No parameters. Width is fixed at 16.
- clk  in  1  system clock. Only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a multiply. Sampled only in IDLE.
- opA  in  16  multiplicand. Captured on an accepted start.
- opB  in  16  multiplier. Captured on an accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- result  out  16  accumulator register. Valid from done; held until the next accepted start.
- ovf  out  1  sticky unsigned overflow of the full product. Valid with result.
- aluA  out  16  ALU A operand.
- aluB  out  16  ALU B operand.
- aluOp  out  3  ALU opcode. 3'h4 = add, 3'h1 = sll.
- aluCin, aluInvA, aluInvB, aluSign  out  1 each  tied 0 in all states.
- aluOut  in  16  ALU result.
- aluOfl  in  1  ALU overflow. With sign=0 it is the unsigned carry-out.

## Operation
- Internal registers:
  - acc[15:0], drives result.
  - mcand[15:0].
  - mplier[15:0].
  - ovf.
- States: IDLE, STEP, ADD, SHIFT, DONE.
- IDLE:
  - On start=1: acc<=0, mcand<=opA, mplier<=opB, ovf<=0; go to STEP.
  - Otherwise stay.
  - result and ovf hold their previous values.
- STEP:
  - If mplier==0, go to DONE.
  - Else if mplier[0]==1, go to ADD.
  - Else go to SHIFT.
- ADD:
  - Drive aluA=acc, aluB=mcand, aluOp=3'h4.
  - acc<=aluOut; ovf<=ovf|aluOfl.
  - Go to SHIFT.
- SHIFT:
  - Drive aluA=mcand, aluB=16'h0001, aluOp=3'h1.
  - mcand<=aluOut; mplier<=mplier>>1.
  - If mcand[15]==1 and (mplier>>1)!=0, then ovf<=1.
  - Go to STEP.
- DONE: done=1; go to IDLE.
- ALU outputs outside ADD/SHIFT: aluA=0, aluB=0, aluOp=3'h4.
- ALU interface is purely combinational from the current state and registers. No ALU result is registered except as written above.
- start while busy is ignored and has no effect on the operation in flight.
- Early termination: iteration stops once the remaining multiplier is zero. The loop never runs more than 16 iterations.
- ovf=1 iff the true 32-bit product is ≥ 2^16.
- result always equals (opA*opB) mod 2^16.

## Timing
- Reset: state=IDLE. busy=0, done=0, result=0, ovf=0, all ALU outputs per the IDLE rule.
- Reset takes effect on any cycle, including mid-operation. The operation is aborted and no done pulse is produced.
- Latency, counted from the clock edge that samples start=1 to the cycle in which done=1:
  - L = 2 + Σ(2 + b_i), summed over i = 0..h.
  - h is the index of the highest set bit of opB. b_i is opB bit i.
  - opB=0 gives L=2.
  - Maximum: opB=16'hFFFF gives L=50.
- busy rises the cycle after start is sampled and falls in the cycle after done.
- done is high for exactly one cycle.
- start may be asserted in the cycle done falls, i.e. back-to-back: IDLE accepts it immediately.
- result/ovf change only on ADD/SHIFT edges and at start acceptance. They are stable from done until the next accepted start.

## Test plan
- opA=3, opB=5 -> done at L=10, result=16'h000F, ovf=0. ALU sees exactly 2 adds and 3 shifts.
- opA=16'h1234, opB=0 -> done at L=2, result=0, ovf=0. No ADD or SHIFT state is entered.
- opA=16'hFFFF, opB=16'hFFFF -> done at L=50, result=16'h0001, ovf=1.
- Shifted-out multiplicand bit:
  - opA=16'h8000, opB=2 -> result=0, ovf=1 (bit lost while mplier was still nonzero).
  - opA=16'h8000, opB=1 -> result=16'h8000, ovf=0.
- Addition carry: opA=16'hFFFF, opB=3 -> carry-out on the second add, result=16'hFFFD, ovf=1.
- Start and reset while busy:
  - Pulse start with new operands during SHIFT of a running 3*5 -> ignored; result=16'h000F.
  - Assert rst during ADD -> next cycle busy=0, result=0, ovf=0, no done pulse.
  - A following start of 7*7 -> result=16'h0031.
